// File: rtl/downstream_accum_arbiter_pkg.sv
// Package cache_def: shared types for the downstream accumulating cache and
// its request arbiter.
//   arb_state_t      arbiter FSM state (idle / transaction outstanding)
//   cpu_req_type     CPU-side request into the cache FSM
//   cpu_result_type  CPU-side result from the cache FSM
//   TIMEOUT_W        width of the arbiter watchdog counter
package cache_def;

  localparam int TIMEOUT_W = 8;
  localparam int IDX_W     = 16;  // cache index field; client occupies [13:4]
  localparam int WORD_W    = 32;  // cache data word

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  rdindex;
    logic [IDX_W-1:0]  wrindex;
    logic [WORD_W-1:0] data;
    logic              rw;     // 1 = accumulate (write), 0 = read
    logic              valid;
  } cpu_req_type;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              ready;
  } cpu_result_type;

endpackage

// File: rtl/downstream_accum_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req    in   N   request vector
//   ptr    in   PW  highest-priority position this decision
//   grant  out  N   one-hot grant (all zero when no request)
//   idx    out  PW  binary index of the granted position
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  logic [PW:0]   sum;
  logic [PW-1:0] pos;
  logic          found;

  // Scan positions ptr, ptr+1, ... wrapping at N; the first requester wins.
  // ptr < N and k < N, so one conditional subtract replaces a modulo.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      pos = sum[PW-1:0];
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/downstream_accum_arbiter.sv
// downstream_accum_arbiter: serialises N_REQ accumulate requesters and one
// read requester onto the single-port downstream cache CPU interface, one
// transaction at a time, with a watchdog on the cache result handshake.
//   clk, rst                 clock / async active-high reset
//   wr_valid/client/amount   accumulate requests (flat, slice i per requester)
//   wr_ready                 one-hot accept pulse
//   rd_valid/client          read request; rd_ready accept pulse
//   rd_data_vld/rd_data      registered read result
//   cpu_req / cpu_res        cache CPU-side request / result
//   busy                     transaction outstanding
//   err_timeout              pulse when the watchdog drops a transaction
// Optional build macro ARB_STATS_EN adds grant_cnt (16 bit per requester) and
// timeout_cnt, both saturating.
module downstream_accum_arbiter
  import cache_def::*;
#(
  parameter int N_REQ       = 4,
  parameter int CID_W       = 10,
  parameter int AMT_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       wr_valid,
  input  logic [N_REQ*CID_W-1:0] wr_client,
  input  logic [N_REQ*AMT_W-1:0] wr_amount,
  output logic [N_REQ-1:0]       wr_ready,
  input  logic                   rd_valid,
  input  logic [CID_W-1:0]       rd_client,
  output logic                   rd_ready,
  output logic                   rd_data_vld,
  output logic [AMT_W-1:0]       rd_data,
  output cpu_req_type            cpu_req,
  input  cpu_result_type         cpu_res,
  output logic                   busy,
  output logic                   err_timeout
`ifdef ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]    grant_cnt,
  output logic [15:0]            timeout_cnt
`endif
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0][CID_W-1:0] cid_a;
  logic [N_REQ-1:0][AMT_W-1:0] amt_a;
  assign cid_a = wr_client;
  assign amt_a = wr_amount;

  arb_state_t           state, state_nxt;
  logic [PW-1:0]        rr_ptr, wr_idx;
  logic [N_REQ-1:0]     wr_gnt;
  logic                 last_was_rd;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 lat_rw;
  logic [CID_W-1:0]     lat_cid;
  logic [AMT_W-1:0]     lat_amt;
  logic                 rd_win, wr_win, res_hit, tmo_hit;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .req   (wr_valid),
    .ptr   (rr_ptr),
    .grant (wr_gnt),
    .idx   (wr_idx)
  );

  // Reads take priority, but never twice in a row while a write waits.
  assign rd_win  = rd_valid && !(last_was_rd && |wr_valid);
  assign wr_win  = !rd_win && |wr_valid;
  assign res_hit = (state == ARB_BUSY) && cpu_res.ready;
  // A ready arriving on the final watchdog cycle still completes normally.
  assign tmo_hit = (state == ARB_BUSY) && !cpu_res.ready &&
                   (wd_cnt == TIMEOUT_W'(TIMEOUT_CYC-1));

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (rd_win || wr_win)   state_nxt = ARB_BUSY;
      ARB_BUSY: if (res_hit || tmo_hit) state_nxt = ARB_IDLE;
      default:                          state_nxt = ARB_IDLE;
    endcase
  end

  // Ready pulses are decided combinationally in IDLE so the requester can
  // move on the very next cycle; gated by rst so reset holds every output low.
  always_comb begin
    wr_ready = '0;
    rd_ready = 1'b0;
    cpu_req  = '0;
    busy     = (state == ARB_BUSY);
    if (state == ARB_IDLE && !rst) begin
      rd_ready = rd_win;
      wr_ready = wr_win ? wr_gnt : '0;
    end
    if (state == ARB_BUSY) begin
      cpu_req.valid = 1'b1;
      cpu_req.rw    = lat_rw;
      if (lat_rw) begin
        cpu_req.wrindex = IDX_W'({lat_cid, 4'b0000});
        cpu_req.data    = WORD_W'(lat_amt);
      end else begin
        cpu_req.rdindex = IDX_W'({lat_cid, 4'b0000});
      end
    end
  end

  // Grant bookkeeping and request latch; the watchdog sits at 0 in IDLE so it
  // starts each transaction cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      last_was_rd <= 1'b0;
      lat_rw      <= 1'b0;
      lat_cid     <= '0;
      lat_amt     <= '0;
      wd_cnt      <= '0;
    end else if (state == ARB_IDLE) begin
      wd_cnt <= '0;
      if (rd_win) begin
        last_was_rd <= 1'b1;
        lat_rw      <= 1'b0;
        lat_cid     <= rd_client;
        lat_amt     <= '0;
      end else if (wr_win) begin
        last_was_rd <= 1'b0;
        lat_rw      <= 1'b1;
        lat_cid     <= cid_a[wr_idx];
        lat_amt     <= amt_a[wr_idx];
        rr_ptr      <= (wr_idx == PW'(N_REQ-1)) ? '0 : wr_idx + 1'b1;
      end
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_vld <= 1'b0;
      rd_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      rd_data_vld <= res_hit && !lat_rw;
      err_timeout <= tmo_hit;
      if (res_hit && !lat_rw) rd_data <= AMT_W'(cpu_res.data);
    end
  end

`ifdef ARB_STATS_EN
  logic [N_REQ-1:0][15:0] gcnt;
  assign grant_cnt = gcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt        <= '0;
      timeout_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (wr_ready[i] && gcnt[i] != 16'hFFFF) gcnt[i] <= gcnt[i] + 16'd1;
      if (tmo_hit && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
    end
  end
`endif

endmodule
